// File: rtl/buffer_serializer.sv
// Parallel-to-serial unloader: captures a packed block of BUF_SIZE words in one
// cycle, then streams them out word 0 first over a valid/ready handshake.
module buffer_serializer #(
  parameter int WIDTH     = 8,
  parameter int BUF_SIZE  = 80,
  parameter int CNT_WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic [BUF_SIZE*WIDTH-1:0] buf_in,
  output logic                      ld_ready,
  input  logic                      abort,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic                      done
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_PTR = CNT_WIDTH'(BUF_SIZE - 1);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic                 done_q, done_d;
  logic [WIDTH-1:0]     shadow_q [BUF_SIZE];
  logic                 at_last;
  logic                 accept;

  assign at_last = (state_q == SEND) && (rd_ptr_q == LAST_PTR);
  assign accept  = (state_q == IDLE) && load && !abort;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_ptr_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_ptr_q <= rd_ptr_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the shadow array is cleared on reset so out_data reads 0 straight
  // out of reset instead of stale or unknown data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < BUF_SIZE; k++) shadow_q[k] <= '0;
    end else if (accept) begin
      for (int k = 0; k < BUF_SIZE; k++) shadow_q[k] <= buf_in[WIDTH*k +: WIDTH];
    end
  end

  // NOTE: every signal gets a default before the branches so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr_q;
    done_d   = 1'b0;
    if (abort) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            state_d  = SEND;
            rd_ptr_d = '0;
          end
        end
        SEND: begin
          if (out_ready) begin
            if (at_last) begin
              state_d  = IDLE;
              rd_ptr_d = '0;
              done_d   = 1'b1;
            end else begin
              rd_ptr_d = rd_ptr_q + 1'b1;
            end
          end
        end
        default: begin
          state_d  = IDLE;
          rd_ptr_d = '0;
        end
      endcase
    end
  end

  // Outputs decode registered state only; out_ready and load never reach them.
  always_comb begin
    ld_ready  = (state_q == IDLE);
    out_valid = (state_q == SEND);
    out_last  = at_last;
    done      = done_q;
    out_data  = shadow_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_buffer_serializer.sv
// Self-checking bench for buffer_serializer: directed phases with random data
// and backpressure, compared each cycle against a queue-based reference model.
module tb_buffer_serializer;

  localparam int WIDTH     = 8;
  localparam int BUF_SIZE  = 80;
  localparam int CNT_WIDTH = 7;

  logic                      clk       = 1'b0;
  logic                      rst_n     = 1'b1;
  logic                      load      = 1'b0;
  logic                      abort     = 1'b0;
  logic                      out_ready = 1'b0;
  logic [BUF_SIZE*WIDTH-1:0] buf_in    = '0;
  logic                      ld_ready;
  logic                      out_valid;
  logic [WIDTH-1:0]          out_data;
  logic                      out_last;
  logic                      done;

  buffer_serializer #(
    .WIDTH    (WIDTH),
    .BUF_SIZE (BUF_SIZE),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .buf_in   (buf_in),
    .ld_ready (ld_ready),
    .abort    (abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: words still to be sent, plus expected done pulse.
  logic [WIDTH-1:0] exp_q[$];
  bit               exp_busy = 1'b0;
  bit               exp_done = 1'b0;
  int               n_loads  = 0;

  // Observations of the DUT per phase.
  int dut_xfers  = 0;
  int dut_dones  = 0;
  int last_edge  = 0;
  int b2b_gap    = -1;
  bit armed      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_seq();
    for (int k = 0; k < BUF_SIZE; k++) buf_in[WIDTH*k +: WIDTH] = WIDTH'(k + 1);
  endtask

  task automatic fill_rand();
    for (int k = 0; k < BUF_SIZE; k++) buf_in[WIDTH*k +: WIDTH] = WIDTH'($urandom);
  endtask

  task automatic fill_const(input logic [WIDTH-1:0] v);
    for (int k = 0; k < BUF_SIZE; k++) buf_in[WIDTH*k +: WIDTH] = v;
  endtask

  task automatic clear_stats();
    dut_xfers = 0;
    dut_dones = 0;
    armed     = 1'b0;
    b2b_gap   = -1;
  endtask

  // Compare outputs against the model, apply inputs, advance one edge, update model.
  task automatic step(input bit ld, input bit ab, input bit rdy);
    bit m_xfer;
    bit d_xfer;
    check("out_valid", out_valid, exp_busy);
    check("ld_ready", ld_ready, !exp_busy);
    check("done", done, exp_done);
    if (exp_busy) begin
      check("out_data", out_data, exp_q[0]);
      check("out_last", out_last, exp_q.size() == 1);
    end else begin
      check("out_last_idle", out_last, 1'b0);
    end
    if (done === 1'b1) dut_dones++;
    d_xfer = (out_valid === 1'b1) && rdy && !ab;
    if (d_xfer) begin
      dut_xfers++;
      if (armed) begin
        b2b_gap = cyc + 1 - last_edge;
        armed   = 1'b0;
      end
      if (out_last === 1'b1) begin
        last_edge = cyc + 1;
        armed     = 1'b1;
      end
    end
    load      = ld;
    abort     = ab;
    out_ready = rdy;
    @(posedge clk);
    cyc++;
    m_xfer   = exp_busy && rdy && !ab;
    exp_done = m_xfer && (exp_q.size() == 1);
    if (ab) begin
      exp_busy = 1'b0;
      exp_q.delete();
    end else if (m_xfer) begin
      void'(exp_q.pop_front());
      if (exp_q.size() == 0) exp_busy = 1'b0;
    end else if (!exp_busy && ld) begin
      for (int k = 0; k < BUF_SIZE; k++) exp_q.push_back(buf_in[WIDTH*k +: WIDTH]);
      exp_busy = 1'b1;
      n_loads++;
    end
    #1;
  endtask

  // Reset asserted mid-cycle; outputs must react with no clock edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_ld_ready", ld_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_out_data", out_data, '0);
    exp_busy = 1'b0;
    exp_done = 1'b0;
    exp_q.delete();
    load  = 1'b0;
    abort = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic drain(input bit random_ready);
    for (int i = 0; i < 2000 && exp_busy; i++)
      step(1'b0, 1'b0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    @(posedge clk);
    #1;
    pulse_reset();
    step(1'b0, 1'b0, 1'b0);

    // Single block, counting values, no backpressure.
    clear_stats();
    fill_seq();
    step(1'b1, 1'b0, 1'b1);
    drain(1'b0);
    check("single_xfers", dut_xfers, 80);
    check("single_dones", dut_dones, 1);

    // Random data with random backpressure.
    clear_stats();
    fill_rand();
    step(1'b1, 1'b0, 1'b0);
    drain(1'b1);
    check("bp_xfers", dut_xfers, 80);
    check("bp_dones", dut_dones, 1);

    // Load presented mid-stream must be ignored.
    clear_stats();
    fill_seq();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() > 71; i++) step(1'b0, 1'b0, 1'b1);
    fill_const(8'hA0);
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    drain(1'b0);
    check("ldsend_xfers", dut_xfers, 80);
    check("ldsend_dones", dut_dones, 1);

    // Abort with a simultaneous load while idle: load must not be accepted.
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);

    // Abort together with a transfer at word 40.
    clear_stats();
    fill_rand();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() > 41; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("abort_xfers", dut_xfers, 39);
    check("abort_dones", dut_dones, 0);
    clear_stats();
    fill_seq();
    step(1'b1, 1'b0, 1'b1);
    drain(1'b0);
    check("post_abort_xfers", dut_xfers, 80);
    check("post_abort_dones", dut_dones, 1);

    // Reset pulsed mid-stream at word 40.
    clear_stats();
    fill_rand();
    step(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 200 && exp_q.size() > 41; i++) step(1'b0, 1'b0, 1'b1);
    pulse_reset();
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("rst_mid_dones", dut_dones, 0);
    clear_stats();
    fill_rand();
    step(1'b1, 1'b0, 1'b1);
    drain(1'b1);
    check("post_rst_xfers", dut_xfers, 80);
    check("post_rst_dones", dut_dones, 1);

    // Back-to-back blocks with load held high.
    clear_stats();
    n_loads = 0;
    fill_rand();
    for (int i = 0; i < 400 && n_loads < 2; i++) begin
      step(1'b1, 1'b0, 1'b1);
      if (n_loads == 1) fill_seq();
    end
    drain(1'b0);
    check("b2b_gap", b2b_gap, 2);
    check("b2b_xfers", dut_xfers, 160);
    check("b2b_dones", dut_dones, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/buffer_serializer.md
# buffer_serializer

Parallel-to-serial unloader: the read-side counterpart of the 80-byte serial-in buffer. It captures one full packed block of `BUF_SIZE` bytes in a single cycle. It then streams the bytes out one per handshake, byte 0 first, over a valid/ready interface. It sits where processed blocks are returned to a byte-wide path, and its packing order matches the collecting buffer's.

## Interface
- `WIDTH`, 8, bits per byte/word.
- `BUF_SIZE`, 80, words per block.
- `CNT_WIDTH`, 7, read-pointer width; must satisfy 2^`CNT_WIDTH` > `BUF_SIZE`.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `load` in 1: request to capture `buf_in`.
- `buf_in` in `BUF_SIZE*WIDTH`: packed block; word k = `buf_in[WIDTH*k+WIDTH-1 : WIDTH*k]`.
- `ld_ready` out 1: high when a load is accepted this cycle.
- `abort` in 1: synchronous; drops the block in flight.
- `out_valid` out 1: `out_data` holds a valid word.
- `out_ready` in 1: downstream accepts the word.
- `out_data` out `WIDTH`: current word.
- `out_last` out 1: current word is word `BUF_SIZE-1`.
- `done` out 1: one-cycle pulse after the final word transfers.

## Operation
- **Shadow storage:**
  - `BUF_SIZE` x `WIDTH` register array `shadow`, a `CNT_WIDTH`-bit `rd_ptr`, and a 2-state FSM (IDLE, SEND).
- **IDLE:**
  - `ld_ready`=1, `out_valid`=0.
  - On `load`=1, all `BUF_SIZE` words are copied from `buf_in` into `shadow`, `rd_ptr` is set to 0, and the FSM moves to SEND.
- **SEND:**
  - `ld_ready`=0, `out_valid`=1, `out_data`=`shadow[rd_ptr]`, `out_last`=(`rd_ptr`==`BUF_SIZE-1`).
  - A transfer is `out_valid` && `out_ready`.
  - On a transfer with `out_last`=0, `rd_ptr` increments.
  - On a transfer with `out_last`=1, `rd_ptr` is set to 0, the FSM moves to IDLE and `done` is registered high for exactly one cycle.
- **Backpressure:** while `out_ready`=0, `rd_ptr`, `out_data` and `out_last` hold. Valid is never withdrawn before a transfer, except on abort or reset.
- **Load during SEND:** ignored. `shadow` and `rd_ptr` are unchanged, and no error is flagged.
- **Abort:** `abort`=1 in any state sets the FSM to IDLE and `rd_ptr` to 0 at the next edge, with no `done` pulse.
  - Abort has priority over a simultaneous transfer and a simultaneous load; the load is not accepted.
  - `shadow` contents are don't-care after abort.
- **Pointer range:** `rd_ptr` never exceeds `BUF_SIZE-1`, and there is no wrap through unused codes.
- **Outputs:** `out_data` is the `shadow` word selected by registered `rd_ptr`. All control outputs are decoded from registered state only; nothing combinational passes from `out_ready` or `load` to any output.

## Timing
- **Reset** (`rst_n`=0, takes effect immediately):
  - FSM=IDLE, `rd_ptr`=0, `done`=0.
  - Hence `ld_ready`=1, `out_valid`=0, `out_last`=0.
  - `out_data`=0: `shadow` is cleared on reset.
- **Reset mid-block:** the stream is abandoned and the state above holds; no `done` pulse.
- **Load latency:** load accepted at edge N means `out_valid`=1 with word 0 from edge N to N+1.
- **Throughput:** with `out_ready` held high, one word per cycle.
  - Word k transfers at edge N+1+k.
  - The last word transfers at edge N+`BUF_SIZE`.
  - `done`=1 and `ld_ready`=1 during the following cycle.
- **Back-to-back blocks:** a new load is accepted at edge N+`BUF_SIZE`+1 at the earliest. This leaves a 1-cycle `out_valid`=0 bubble between blocks, which is the required behaviour.
- **`done` with load:** `done` coincides with the first IDLE cycle. A load in that same cycle is accepted.

## Test plan
- **Reset values:** assert `rst_n`=0 mid-cycle, with no clock edge -> immediately `ld_ready`=1, `out_valid`=0, `out_last`=0, `done`=0, `out_data`=0.
- **Single block, no backpressure:**
  - Stimulus: `buf_in` word k = k+1 (1..80); `load` for 1 cycle; `out_ready`=1.
  - Required: words 1..80 appear in 80 consecutive cycles; `out_last` only on value 80; `done` is a single pulse in the next cycle.
- **Random backpressure:**
  - Stimulus: `out_ready` toggled pseudo-randomly at 50%.
  - Required: exactly 80 transfers, in order; `out_data` is stable across every stalled cycle; `out_valid` never drops before the final transfer.
- **Load during SEND:**
  - Stimulus: second block, word k = 0xA0 applied with `load`=1 at word 10 of a stream.
  - Required: the stream continues with original words 11..80; `ld_ready`=0 throughout.
- **Abort and reset mid-stream:**
  - Abort asserted together with `out_ready`=1 at word 40 -> word 40 is not counted, and the next cycle shows IDLE with no `done`.
  - A new block then streams from word 0.
  - Repeat with `rst_n` pulsed low at word 40 -> same result.
- **Back-to-back:**
  - Stimulus: `load` held high continuously with two distinct blocks.
  - Required: block 2 word 0 appears exactly 2 cycles after block 1's last transfer (1 bubble); `done` pulses once per block.
